// File: rtl/bcd_countdown_timer.sv
// BCD minutes:seconds countdown timer with shift-loading, pause, +30 s quick-add
// and a registered terminal-count pulse. Minute digits are stored LS-first.
module bcd_countdown_timer #(
  parameter int MIN_DIGITS = 1,
  parameter int TICK_DIV   = 1
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic                    loadn,
  input  logic                    stb,
  input  logic [3:0]              data,
  input  logic                    en,
  input  logic                    add30,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic                    zero,
  output logic                    tc
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [3:0]            ones_reg, ones_next;
  logic [3:0]            tens_reg, tens_next;
  logic [3:0]            min_reg  [MIN_DIGITS];
  logic [3:0]            min_next [MIN_DIGITS];
  logic [3:0]            min_dec  [MIN_DIGITS];
  logic [3:0]            min_inc  [MIN_DIGITS];
  logic [MIN_DIGITS-1:0] min_is_zero;
  logic [PW-1:0]         presc_reg, presc_next;
  logic                  tc_reg, tc_next;
  logic                  min_all_nine;
  logic                  tens_ge3;
  logic                  add_eff;
  logic                  at_last;
  logic                  tick;
  logic [3:0]            data_clamped;

  genvar gi;
  generate
    for (gi = 0; gi < MIN_DIGITS; gi++) begin : g_digit
      assign min_is_zero[gi]  = (min_reg[gi] == 4'd0);
      assign mins[4*gi +: 4]  = min_reg[gi];
    end
  endgenerate

  assign sec_ones     = ones_reg;
  assign sec_tens     = tens_reg;
  assign tc           = tc_reg;
  assign zero         = (ones_reg == 4'd0) && (tens_reg == 4'd0) && (&min_is_zero);
  assign tens_ge3     = (tens_reg >= 4'd3);
  assign data_clamped = (data > 4'd9) ? 4'd9 : data;
  assign at_last      = (presc_reg == PRESC_LAST);

  // Borrow (decrement) and carry (+1 minute) ripple through the minute digits.
  always_comb begin
    logic borrow_c;
    logic carry_c;
    borrow_c = (ones_reg == 4'd0) && (tens_reg == 4'd0);
    carry_c  = tens_ge3;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      min_dec[i] = min_reg[i];
      min_inc[i] = min_reg[i];
      if (borrow_c) min_dec[i] = (min_reg[i] == 4'd0) ? 4'd9 : min_reg[i] - 4'd1;
      if (carry_c)  min_inc[i] = (min_reg[i] == 4'd9) ? 4'd0 : min_reg[i] + 4'd1;
      borrow_c = borrow_c && (min_reg[i] == 4'd0);
      carry_c  = carry_c && (min_reg[i] == 4'd9);
    end
    min_all_nine = carry_c;
  end

  // A +30 s that would overflow the top minute digit is dropped entirely.
  assign add_eff = loadn && add30 && !min_all_nine;
  assign tick    = loadn && en && !zero && at_last && !add_eff;

  always_comb begin
    ones_next  = ones_reg;
    tens_next  = tens_reg;
    min_next   = min_reg;
    presc_next = presc_reg;
    tc_next    = 1'b0;
    if (!loadn) begin
      presc_next = '0;
      if (stb) begin
        for (int i = MIN_DIGITS - 1; i > 0; i--) begin
          min_next[i] = min_reg[i-1];
        end
        min_next[0] = tens_reg;
        tens_next   = ones_reg;
        ones_next   = data_clamped;
      end
    end else begin
      if (zero) begin
        presc_next = '0;
      end else if (en) begin
        // add30 on the tick edge defers the tick by holding the prescaler.
        if (at_last) presc_next = add_eff ? presc_reg : '0;
        else         presc_next = presc_reg + PW'(1);
      end

      if (add_eff) begin
        if (tens_ge3) begin
          tens_next = tens_reg - 4'd3;
          min_next  = min_inc;
        end else begin
          tens_next = tens_reg + 4'd3;
        end
      end else if (tick) begin
        ones_next = (ones_reg == 4'd0) ? 4'd9 : ones_reg - 4'd1;
        if (ones_reg == 4'd0) tens_next = (tens_reg == 4'd0) ? 4'd5 : tens_reg - 4'd1;
        min_next = min_dec;
        tc_next  = (ones_reg == 4'd1) && (tens_reg == 4'd0) && (&min_is_zero);
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ones_reg  <= 4'd0;
      tens_reg  <= 4'd0;
      presc_reg <= '0;
      tc_reg    <= 1'b0;
      for (int i = 0; i < MIN_DIGITS; i++) min_reg[i] <= 4'd0;
    end else begin
      ones_reg  <= ones_next;
      tens_reg  <= tens_next;
      presc_reg <= presc_next;
      tc_reg    <= tc_next;
      for (int i = 0; i < MIN_DIGITS; i++) min_reg[i] <= min_next[i];
    end
  end

endmodule
